// File: rtl/j_mmult_pkg.sv
// ---------------------------------------------------------------------------
// j_mmult_pkg : shared state encoding and constants for the MMULT sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package j_mmult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int MIN_WIDTH  = 3;
  localparam int ELEM_BYTES = 4;

  // Widths below the systolic minimum are promoted rather than rejected.
  function automatic logic [3:0] clamp_width(input logic [3:0] w);
    return (w < 4'(MIN_WIDTH)) ? 4'(MIN_WIDTH) : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/j_mmult_cnt.sv
// ---------------------------------------------------------------------------
// j_mmult_cnt : element index up-counter with sync clear and last compare
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module j_mmult_cnt #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] last_val,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl)    count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + CW'(1);
  end

  assign last = (count == last_val);

endmodule

`default_nettype wire

// File: rtl/j_mmult_seq.sv
// ---------------------------------------------------------------------------
// j_mmult_seq : MMULT sequencer (element fetch, MAC strobes, drain, done).
// Optional MMULT_STALL_CNT_EN adds a saturating RUN stall counter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module j_mmult_seq
  import j_mmult_pkg::*;
#(
  parameter int AW       = 24,
  parameter int CW       = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    mtx_width,
  input  logic          mtx_col,
  input  logic [AW-1:0] mtx_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  output logic          mac_en,
  output logic          mac_clr,
  output logic [CW-2:0] reg_idx,
  output logic          reg_hi,
  output logic          busy,
  output logic          done
`ifdef MMULT_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t        state, state_nx;
  logic [3:0]    w_q;
  logic [AW-1:0] base_q, stride_q, addr_q;
  logic [DW-1:0] drain_q;
  logic [CW-1:0] count;
  logic          last;
  logic          go, accept;
  logic [3:0]    w_in;

  assign w_in   = clamp_width(mtx_width);
  assign go     = (state == ST_IDLE) && start && !abort;
  assign accept = (state == ST_RUN) && mem_ack && !abort;

  j_mmult_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .resetl   (resetl),
    .clr      (state == ST_LOAD),
    .en       (accept && !last),
    .last_val (CW'(w_q) - CW'(1)),
    .count    (count),
    .last     (last)
  );

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (abort && state != ST_IDLE) begin
      state_nx = ST_IDLE;
      mem_req  = (state == ST_RUN);
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nx = ST_LOAD;
        ST_LOAD: begin
          mac_clr  = 1'b1;
          busy     = 1'b1;
          state_nx = ST_RUN;
        end
        ST_RUN: begin
          mem_req = 1'b1;
          busy    = 1'b1;
          mac_en  = accept;
          if (accept && last) state_nx = ST_DRAIN;
        end
        ST_DRAIN: begin
          busy = 1'b1;
          if (drain_q == DW'(PIPE_LAT - 1)) state_nx = ST_DONE;
        end
        ST_DONE: begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Config is captured only on an accepted start, so starts while busy are inert.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      w_q      <= '0;
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      drain_q  <= '0;
    end else begin
      if (go) begin
        w_q      <= w_in;
        base_q   <= mtx_addr;
        stride_q <= mtx_col ? AW'(w_in) * AW'(ELEM_BYTES) : AW'(ELEM_BYTES);
      end
      if (state == ST_LOAD)        addr_q <= base_q;
      else if (accept && !last)    addr_q <= addr_q + stride_q;
      if (state == ST_DRAIN)       drain_q <= drain_q + DW'(1);
      else                         drain_q <= '0;
    end
  end

  assign mem_addr = addr_q;
  assign reg_idx  = count[CW-1:1];
  assign reg_hi   = count[0];

`ifdef MMULT_STALL_CNT_EN
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl)
      stall_cnt <= '0;
    else if (state == ST_LOAD)
      stall_cnt <= '0;
    else if (state == ST_RUN && !mem_ack && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_j_mmult_seq.sv
// ---------------------------------------------------------------------------
// tb_j_mmult_seq : self-checking bench for j_mmult_seq against an address model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_j_mmult_seq;

  localparam int AW = 24;
  localparam int CW = 6;
  localparam int PIPE_LAT = 2;

  logic          clk = 1'b0;
  logic          resetl = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    mtx_width = '0;
  logic          mtx_col = 1'b0;
  logic [AW-1:0] mtx_addr = '0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mac_en, mac_clr, reg_hi, busy, done;
  logic [AW-1:0] mem_addr;
  logic [CW-2:0] reg_idx;
`ifdef MMULT_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] obs_addr[$];
  int            obs_idx[$];
  int            obs_hi[$];
  int obs_done_cyc, obs_done_cnt, obs_clr_cnt, obs_unstable;
  int obs_req_cyc, obs_stall_cyc, obs_busy_bad;

  j_mmult_seq #(.AW(AW), .CW(CW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .resetl(resetl), .start(start), .abort(abort),
    .mtx_width(mtx_width), .mtx_col(mtx_col), .mtx_addr(mtx_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mac_en(mac_en), .mac_clr(mac_clr), .reg_idx(reg_idx), .reg_hi(reg_hi),
    .busy(busy), .done(done)
`ifdef MMULT_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int clamp_w(input int w);
    return (w < 3) ? 3 : w;
  endfunction

  // Element i lives at base + i*stride, modulo the address space.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int w,
                                             input bit col, input int i);
    longint unsigned a;
    a = longint'(base) + longint'(i) * (col ? longint'(clamp_w(w) * 4) : 64'd4);
    return a[AW-1:0];
  endfunction

  // Drives one operation and records what the DUT did; mode 0 = ack always,
  // 1 = ack every third request cycle, 2 = random ack. restart_cyc>0 pulses a
  // conflicting start at that cycle.
  task automatic run_op(input int w, input bit col, input logic [AW-1:0] base,
                        input int mode, input int restart_cyc);
    int req_seen = 0;
    bit prev_req = 0, prev_ack = 0;
    logic [AW-1:0] prev_addr = '0;
    obs_addr.delete(); obs_idx.delete(); obs_hi.delete();
    obs_done_cyc = -1; obs_done_cnt = 0; obs_clr_cnt = 0; obs_unstable = 0;
    obs_req_cyc = 0; obs_stall_cyc = 0; obs_busy_bad = 0;
    @(negedge clk);
    start = 1'b1; mtx_width = w[3:0]; mtx_col = col; mtx_addr = base; mem_ack = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      if (start) begin
        mtx_width = 4'd15; mtx_col = ~col; mtx_addr = ~base;
      end
      case (mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = (req_seen % 3 == 2);
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (mac_clr) obs_clr_cnt++;
      if (mem_req) begin
        if (prev_req && !prev_ack && mem_addr !== prev_addr) obs_unstable++;
        obs_req_cyc++;
        if (!mem_ack) obs_stall_cyc++;
        req_seen++;
      end
      if (mac_en) begin
        obs_addr.push_back(mem_addr);
        obs_idx.push_back(int'(reg_idx));
        obs_hi.push_back(int'(reg_hi));
      end
      if (!busy && !done) obs_busy_bad++;
      if (done) begin
        obs_done_cyc = cyc;
        obs_done_cnt++;
        if (busy) obs_busy_bad++;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      if (done) break;
    end
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({mem_req, mac_en, mac_clr, reg_hi, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {mem_req, mac_en, mac_clr, reg_hi, busy, done});
    end
    checks++;
    if (mem_addr !== '0 || reg_idx !== '0) begin
      errors++;
      $display("FAIL reset_addr: got addr=%h idx=%0d expected 0/0", mem_addr, reg_idx);
    end
`ifdef MMULT_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    @(negedge clk);
    resetl = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_row();
    run_op(3, 1'b0, 24'hF1B000, 0, 0);
    checks++;
    if (obs_addr.size() != 3) begin
      errors++;
      $display("FAIL row_count: got %0d mac_en expected 3", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr(24'hF1B000, 3, 1'b0, i) || obs_idx[i] != (i >> 1) || obs_hi[i] != (i & 1)) begin
        errors++;
        $display("FAIL row_elem[%0d]: got addr=%h idx=%0d hi=%0d expected addr=%h idx=%0d hi=%0d",
                 i, obs_addr[i], obs_idx[i], obs_hi[i], exp_addr(24'hF1B000, 3, 1'b0, i), i >> 1, i & 1);
      end
    end
    checks++;
    if (obs_done_cyc != 1 + 3 + PIPE_LAT + 1) begin
      errors++;
      $display("FAIL row_latency: got %0d expected %0d", obs_done_cyc, 1 + 3 + PIPE_LAT + 1);
    end
    checks++;
    if (obs_clr_cnt != 1 || obs_done_cnt != 1 || obs_busy_bad != 0) begin
      errors++;
      $display("FAIL row_strobes: got clr=%0d done=%0d busy_bad=%0d expected 1/1/0",
               obs_clr_cnt, obs_done_cnt, obs_busy_bad);
    end
  endtask

  task automatic test_col();
    run_op(4, 1'b1, 24'hF1B100, 0, 0);
    checks++;
    if (obs_addr.size() != 4) begin
      errors++;
      $display("FAIL col_count: got %0d expected 4", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr(24'hF1B100, 4, 1'b1, i)) begin
        errors++;
        $display("FAIL col_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(24'hF1B100, 4, 1'b1, i));
      end
    end
    checks++;
    if (obs_done_cyc != 1 + 4 + PIPE_LAT + 1) begin
      errors++;
      $display("FAIL col_latency: got %0d expected %0d", obs_done_cyc, 1 + 4 + PIPE_LAT + 1);
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] base = AW'($urandom);
    run_op(5, 1'b0, base, 1, 0);
    checks++;
    if (obs_addr.size() != 5 || obs_unstable != 0) begin
      errors++;
      $display("FAIL stall_macs: got mac_en=%0d unstable=%0d expected 5/0", obs_addr.size(), obs_unstable);
    end
    for (int i = 0; i < obs_addr.size() && i < 5; i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr(base, 5, 1'b0, i)) begin
        errors++;
        $display("FAIL stall_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(base, 5, 1'b0, i));
      end
    end
    checks++;
    if (obs_done_cyc != 1 + 15 + PIPE_LAT + 1) begin
      errors++;
      $display("FAIL stall_latency: got %0d expected %0d", obs_done_cyc, 1 + 15 + PIPE_LAT + 1);
    end
`ifdef MMULT_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected 10", stall_cnt);
    end
`endif
  endtask

  task automatic test_clamp();
    for (int k = 0; k < 3; k++) begin
      bit col = (k == 2);
      run_op(k == 1 ? 1 : 0, col, 24'h000200, 0, 0);
      checks++;
      if (obs_addr.size() != 3) begin
        errors++;
        $display("FAIL clamp_count[%0d]: got %0d expected 3", k, obs_addr.size());
      end
      if (obs_addr.size() == 3) begin
        checks++;
        if (obs_addr[2] !== exp_addr(24'h000200, 0, col, 2)) begin
          errors++;
          $display("FAIL clamp_addr[%0d]: got %h expected %h", k, obs_addr[2], exp_addr(24'h000200, 0, col, 2));
        end
      end
    end
  endtask

  task automatic test_abort();
    int n = 0, dn = 0;
    @(negedge clk);
    start = 1'b1; mtx_width = 4'd6; mtx_col = 1'b0; mtx_addr = 24'h123450; mem_ack = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (mac_en) n++;
    end
    @(negedge clk);
    abort = 1'b1; mem_ack = 1'b1;
    #1;
    checks++;
    if (mac_en !== 1'b0 || n != 2) begin
      errors++;
      $display("FAIL abort_mac: got mac_en=%b after %0d acks expected 0 after 2", mac_en, n);
    end
    @(negedge clk);
    abort = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b mem_req=%b expected 0/0", busy, mem_req);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (done) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", dn);
    end
    run_op(4, 1'b1, 24'hABC000, 0, 0);
    checks++;
    if (obs_clr_cnt != 1 || obs_addr.size() != 4 || obs_done_cnt != 1) begin
      errors++;
      $display("FAIL abort_rerun: got clr=%0d macs=%0d done=%0d expected 1/4/1",
               obs_clr_cnt, obs_addr.size(), obs_done_cnt);
    end
    if (obs_addr.size() == 4) begin
      checks++;
      if (obs_addr[0] !== 24'hABC000 || obs_addr[3] !== exp_addr(24'hABC000, 4, 1'b1, 3)) begin
        errors++;
        $display("FAIL abort_rerun_addr: got %h/%h expected %h/%h", obs_addr[0], obs_addr[3],
                 24'hABC000, exp_addr(24'hABC000, 4, 1'b1, 3));
      end
    end
  endtask

  task automatic test_busy_start_and_reset();
    int n = 0;
    run_op(7, 1'b0, 24'h0FFFF0, 0, 3);
    checks++;
    if (obs_addr.size() != 7 || obs_clr_cnt != 1 || obs_done_cyc != 1 + 7 + PIPE_LAT + 1) begin
      errors++;
      $display("FAIL busy_start: got macs=%0d clr=%0d done_cyc=%0d expected 7/1/%0d",
               obs_addr.size(), obs_clr_cnt, obs_done_cyc, 1 + 7 + PIPE_LAT + 1);
    end
    for (int i = 0; i < obs_addr.size() && i < 7; i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr(24'h0FFFF0, 7, 1'b0, i)) begin
        errors++;
        $display("FAIL busy_start_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(24'h0FFFF0, 7, 1'b0, i));
      end
    end
    @(negedge clk);
    start = 1'b1; mtx_width = 4'd8; mtx_col = 1'b1; mtx_addr = 24'h555000; mem_ack = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (mac_en) n++;
    end
    #2;
    resetl = 1'b0;
    #1;
    checks++;
    if ({mem_req, mac_en, mac_clr, reg_hi, busy, done} !== 6'b0 || mem_addr !== '0 || reg_idx !== '0) begin
      errors++;
      $display("FAIL async_reset: got ctrl=%b addr=%h idx=%0d expected 0", {mem_req, mac_en, mac_clr, reg_hi, busy, done},
               mem_addr, reg_idx);
    end
    @(negedge clk);
    resetl = 1'b1; mem_ack = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b mem_req=%b expected 0/0", busy, mem_req);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int w = $urandom_range(0, 15);
      bit col = 1'($urandom_range(0, 1));
      logic [AW-1:0] base = (it == 0) ? 24'hFFFFF8 : AW'($urandom);
      if (it == 0) begin w = 15; col = 1'b1; end
      run_op(w, col, base, 2, 0);
      checks++;
      if (obs_addr.size() != clamp_w(w) || obs_done_cnt != 1 || obs_unstable != 0 || obs_busy_bad != 0) begin
        errors++;
        $display("FAIL rand[%0d]_op: got macs=%0d done=%0d unstable=%0d busy_bad=%0d expected %0d/1/0/0",
                 it, obs_addr.size(), obs_done_cnt, obs_unstable, obs_busy_bad, clamp_w(w));
      end
      for (int i = 0; i < obs_addr.size() && i < clamp_w(w); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr(base, w, col, i) || obs_idx[i] != (i >> 1) || obs_hi[i] != (i & 1)) begin
          errors++;
          $display("FAIL rand[%0d]_elem[%0d]: got addr=%h idx=%0d hi=%0d expected addr=%h idx=%0d hi=%0d",
                   it, i, obs_addr[i], obs_idx[i], obs_hi[i], exp_addr(base, w, col, i), i >> 1, i & 1);
        end
      end
      checks++;
      if (obs_done_cyc != 1 + obs_req_cyc + PIPE_LAT + 1) begin
        errors++;
        $display("FAIL rand[%0d]_latency: got %0d expected %0d", it, obs_done_cyc, 1 + obs_req_cyc + PIPE_LAT + 1);
      end
`ifdef MMULT_STALL_CNT_EN
      checks++;
      if (int'(stall_cnt) != obs_stall_cyc) begin
        errors++;
        $display("FAIL rand[%0d]_stall_cnt: got %0d expected %0d", it, stall_cnt, obs_stall_cyc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_row();
    test_col();
    test_stall();
    test_clamp();
    test_abort();
    test_busy_start_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
